// File: rtl/risc8_mem_arbiter.sv
// Arbitrates one single-port 8-bit memory between instruction fetch and data/stack
// accesses; one access outstanding, data priority with a fetch anti-starvation counter.
module risc8_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [7:0]  if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [7:0]  d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        pc_halt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t      state, state_nxt;
    logic        own_fetch;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [1:0]  wait_cnt;
    logic [2:0]  starve_cnt;
    logic        fetch_pri;

    assign fetch_pri = (starve_cnt == 3'(STARVE_MAX));
    assign pc_halt   = if_req & ~if_gnt;

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && fetch_pri)) begin
                    d_gnt = 1'b1;
                end else if (if_req) begin
                    if_gnt = 1'b1;
                end
                if (d_gnt || if_gnt) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                // Only data accesses can be writes, so a write completes on d_rvalid here.
                if (we_q) begin
                    d_rvalid  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'(MEM_LAT)) begin
                    state_nxt = IDLE;
                    if (own_fetch) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset aborts any access in flight: no grant, strobe or late read data escapes.
        if (rst) begin
            state_nxt = IDLE;
            if_gnt    = 1'b0;
            d_gnt     = 1'b0;
            if_rvalid = 1'b0;
            if_rdata  = '0;
            d_rvalid  = 1'b0;
            d_rdata   = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            own_fetch  <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (d_gnt) begin
                own_fetch <= 1'b0;
                addr_q    <= d_addr;
                we_q      <= d_we;
                wdata_q   <= d_wdata;
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (!fetch_pri) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end else if (if_gnt) begin
                own_fetch  <= 1'b1;
                addr_q     <= if_addr;
                we_q       <= 1'b0;
                wdata_q    <= '0;
                starve_cnt <= '0;
            end
            if (state == ISSUE) begin
                wait_cnt <= 2'd1;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc8_mem_arbiter.sv
// Directed bench for risc8_mem_arbiter: MEM_LAT=1 instance for most scenarios,
// MEM_LAT=3 instance for the long-latency read.
module tb_risc8_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [15:0] if_addr = '0, d_addr = '0;
    logic [7:0]  d_wdata = '0, mem_rdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, pc_halt;
    logic [7:0]  if_rdata, d_rdata, mem_wdata;
    logic [15:0] mem_addr;

    logic        l3_if_req = 0;
    logic [15:0] l3_if_addr = '0;
    logic [7:0]  l3_mem_rdata = '0;
    logic        l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_mem_en, l3_mem_we, l3_pc_halt;
    logic [7:0]  l3_if_rdata, l3_d_rdata, l3_mem_wdata;
    logic [15:0] l3_mem_addr;

    int vectors = 0;
    int miscompares = 0;

    risc8_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pc_halt(pc_halt)
    );

    risc8_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt), .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(8'h00),
        .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_rdata(l3_mem_rdata), .pc_halt(l3_pc_halt)
    );

    logic [46:0] all_out, all_out3;
    assign all_out  = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                       mem_en, mem_we, mem_addr, mem_wdata, pc_halt};
    assign all_out3 = {l3_if_gnt, l3_if_rvalid, l3_if_rdata, l3_d_gnt, l3_d_rvalid, l3_d_rdata,
                       l3_mem_en, l3_mem_we, l3_mem_addr, l3_mem_wdata, l3_pc_halt};

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if_req = 0; d_req = 0; d_we = 0; l3_if_req = 0;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1; if_req = 1; d_req = 1;
            #1;
            vectors++;
            if ({if_gnt, d_gnt, pc_halt, mem_en, d_rvalid, if_rvalid} !== 6'b001000) begin
                miscompares++;
                $display("FAIL reset_no_grant got %b exp 001000", {if_gnt, d_gnt, pc_halt, mem_en, d_rvalid, if_rvalid});
            end
        end
        @(negedge clk);
        rst = 0; if_req = 0; d_req = 0;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        vectors++;
        if (all_out3 !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_lat3 got %h exp 0", all_out3);
        end
    endtask

    task automatic test_fetch_read;
        // cycle 0: grant
        @(negedge clk);
        if_req = 1; if_addr = 16'h0010;
        #1;
        vectors++;
        if ({if_gnt, d_gnt, pc_halt} !== 3'b100) begin
            miscompares++;
            $display("FAIL fetch_gnt got %b exp 100", {if_gnt, d_gnt, pc_halt});
        end
        // cycle 1: issue, request still held but no new grant
        @(negedge clk);
        if_addr = 16'h0020;
        #1;
        vectors++;
        if ({mem_en, mem_we, mem_addr, if_gnt, pc_halt, if_rvalid} !== {1'b1, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_issue got %b_%b_%h_%b%b%b exp 1_0_0010_010",
                     mem_en, mem_we, mem_addr, if_gnt, pc_halt, if_rvalid);
        end
        // cycle 2: data returns
        @(negedge clk);
        mem_rdata = 8'hA5;
        #1;
        vectors++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata, mem_en, if_gnt} !== {1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_rvalid got %b_%h_%b_%h_%b_%b exp 1_a5_0_00_0_0",
                     if_rvalid, if_rdata, d_rvalid, d_rdata, mem_en, if_gnt);
        end
        // cycle 3: earliest next grant
        @(negedge clk);
        mem_rdata = 8'h00;
        #1;
        vectors++;
        if ({if_gnt, if_rvalid, if_rdata} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL fetch_regrant got %b_%b_%h exp 1_0_00", if_gnt, if_rvalid, if_rdata);
        end
        idle_cycles(4);
    endtask

    task automatic test_data_write;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 16'hFFFF; d_wdata = 8'h3C;
        #1;
        vectors++;
        if ({d_gnt, if_gnt, mem_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL write_gnt got %b exp 100", {d_gnt, if_gnt, mem_en});
        end
        @(negedge clk);
        d_req = 0; d_we = 0; d_addr = 16'h0000; d_wdata = 8'h00;
        #1;
        vectors++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, d_rvalid, d_rdata, if_rvalid} !==
            {1'b1, 1'b1, 16'hFFFF, 8'h3C, 1'b1, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL write_issue got %b_%b_%h_%h_%b_%h_%b exp 1_1_ffff_3c_1_00_0",
                     mem_en, mem_we, mem_addr, mem_wdata, d_rvalid, d_rdata, if_rvalid);
        end
        // cycle 2: back in IDLE, a data read is granted immediately
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 16'h1234;
        #1;
        vectors++;
        if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL write_back_to_back got %b exp 1000", {d_gnt, mem_en, mem_we, d_rvalid});
        end
        @(negedge clk);
        d_req = 0;
        #1;
        vectors++;
        if ({mem_en, mem_we, mem_addr, d_rvalid} !== {1'b1, 1'b0, 16'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL dread_issue got %b_%b_%h_%b exp 1_0_1234_0", mem_en, mem_we, mem_addr, d_rvalid);
        end
        @(negedge clk);
        mem_rdata = 8'h5A;
        #1;
        vectors++;
        if ({d_rvalid, d_rdata, if_rvalid, if_rdata} !== {1'b1, 8'h5A, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL dread_rvalid got %b_%h_%b_%h exp 1_5a_0_00", d_rvalid, d_rdata, if_rvalid, if_rdata);
        end
        idle_cycles(3);
        mem_rdata = 8'h00;
    endtask

    task automatic test_starvation;
        logic [4:0] exp;
        logic [7:0] exp_rd;
        mem_rdata = 8'h77;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if_req = 1; if_addr = 16'h0100; d_req = 1; d_we = 1; d_addr = 16'(c); d_wdata = 8'(c);
            #1;
            // {if_gnt, d_gnt, d_rvalid, if_rvalid, pc_halt}
            case (c)
                0, 2, 4, 9, 11, 13: exp = 5'b01001;
                1, 3, 5, 10, 12, 14: exp = 5'b00101;
                6, 15:               exp = 5'b10000;
                8:                   exp = 5'b00011;
                default:             exp = 5'b00001;
            endcase
            exp_rd = (c == 8) ? 8'h77 : 8'h00;
            vectors++;
            if ({if_gnt, d_gnt, d_rvalid, if_rvalid, pc_halt, if_rdata} !== {exp, exp_rd}) begin
                miscompares++;
                $display("FAIL starve_c%0d got %b_%h exp %b_%h", c,
                         {if_gnt, d_gnt, d_rvalid, if_rvalid, pc_halt}, if_rdata, exp, exp_rd);
            end
        end
        idle_cycles(4);
        mem_rdata = 8'h00;
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 16'h00C0;
        #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_gnt got %b exp 1", d_gnt);
        end
        @(negedge clk);
        rst = 1; d_req = 0;
        #1;
        vectors++;
        if ({d_rvalid, if_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_c1 got %b exp 00", {d_rvalid, if_rvalid});
        end
        // cycle 2: late read data present, must be ignored; IDLE so a new write is granted
        @(negedge clk);
        rst = 0; mem_rdata = 8'hEE; d_req = 1; d_we = 1; d_addr = 16'h0042; d_wdata = 8'h11;
        #1;
        vectors++;
        if (all_out !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL rstmid_c2 got %h exp only d_gnt set", all_out);
        end
        @(negedge clk);
        d_req = 0; d_we = 0;
        #1;
        vectors++;
        if ({d_rvalid, d_rdata, mem_addr, mem_wdata} !== {1'b1, 8'h00, 16'h0042, 8'h11}) begin
            miscompares++;
            $display("FAIL rstmid_c3 got %b_%h_%h_%h exp 1_00_0042_11", d_rvalid, d_rdata, mem_addr, mem_wdata);
        end
        idle_cycles(3);
        mem_rdata = 8'h00;
    endtask

    task automatic test_lat3_read;
        logic [10:0] exp;
        @(negedge clk);
        l3_if_req = 1; l3_if_addr = 16'hBEEF;
        #1;
        vectors++;
        if (l3_if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL lat3_gnt got %b exp 1", l3_if_gnt);
        end
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            l3_if_req = 0; l3_mem_rdata = 8'h3C;
            #1;
            // {mem_en, if_rvalid, if_rdata, d_rvalid}
            exp = {(c == 1), (c == 4), (c == 4) ? 8'h3C : 8'h00, 1'b0};
            vectors++;
            if ({l3_mem_en, l3_if_rvalid, l3_if_rdata, l3_d_rvalid} !== exp) begin
                miscompares++;
                $display("FAIL lat3_c%0d got %b exp %b", c,
                         {l3_mem_en, l3_if_rvalid, l3_if_rdata, l3_d_rvalid}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_write();
        test_starvation();
        test_reset_mid_read();
        test_lat3_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
